cnt_seq_checker: RTL and testbench

Receive-side checker for the 4-bit count streams produced by the team's counter blocks. It samples a count bus, verifies that each valid sample is the previous one plus one (modulo CNT_MAX+1), declares lock after a run of correct steps, and reports wrap events, sequence errors and a saturating error total. It sits directly downstream of a counter output (`po_cnt`) in the lesson designs and in their benches.

---
 rtl/cnt_chk_pkg.sv | 14 +
 rtl/cnt_sat_inc.sv | 19 +
 rtl/cnt_seq_checker.sv | 105 ++++++++++
 tb/tb_cnt_seq_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared types and defaults for the count-sequence checker.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int CNT_W       = 4;
  localparam int CNT_MAX_DEF = 15;
  localparam int LOCK_N_DEF  = 4;

endpackage

// File: rtl/cnt_sat_inc.sv
// Up-counter that sticks at all-ones instead of wrapping.
module cnt_sat_inc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Checks that a valid-qualified count stream steps by one modulo CNT_MAX+1;
// locks after LOCK_N correct steps and reports wraps and locked-state errors.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int LOCK_N  = LOCK_N_DEF,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] pi_cnt,
  input  logic             pi_vld,
  output logic             po_lock,
  output logic             po_wrap,
  output logic             po_err,
  output logic [ERR_W-1:0] po_err_cnt
);

  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W:0]   C_LOCK = (CNT_W + 1)'(LOCK_N);

  state_t           r_state;
  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_run;
  logic             r_lock;
  logic             r_wrap;
  logic             r_err;

  logic             w_prev_max;
  logic [CNT_W-1:0] w_expect;
  logic             w_correct;
  logic [CNT_W:0]   w_run_nxt;
  logic             w_err_inc;

  // Out-of-range samples can never match, even if prev itself was out of range.
  always_comb begin
    w_prev_max = (r_prev == C_MAX);
    w_expect   = w_prev_max ? '0 : r_prev + 1'b1;
    w_correct  = pi_vld && (pi_cnt <= C_MAX) && (pi_cnt == w_expect);
    w_run_nxt  = {1'b0, r_run} + 1'b1;
    w_err_inc  = pi_vld && (r_state == LOCK) && !w_correct;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_run   <= '0;
      r_lock  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (pi_vld) begin
        r_prev <= pi_cnt;
        case (r_state)
          IDLE: begin
            r_run   <= '0;
            r_state <= HUNT;
          end
          HUNT: begin
            if (w_correct) begin
              if (w_run_nxt == C_LOCK) begin
                r_state <= LOCK;
                r_lock  <= 1'b1;
                r_run   <= '0;
              end else begin
                r_run <= w_run_nxt[CNT_W-1:0];
              end
            end else begin
              r_run <= '0;
            end
          end
          LOCK: begin
            if (w_correct) begin
              r_wrap <= w_prev_max;
            end else begin
              r_err   <= 1'b1;
              r_lock  <= 1'b0;
              r_run   <= '0;
              r_state <= HUNT;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  cnt_sat_inc #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_err_inc),
    .q   (po_err_cnt)
  );

  assign po_lock = r_lock;
  assign po_wrap = r_wrap;
  assign po_err  = r_err;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Scoreboard bench: three checker instances (default, CNT_MAX=9, ERR_W=2) share one stimulus.
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       vld = 1'b0;
  int         sel = 0;

  logic       l0, w0, e0, l1, w1, e1, l2, w2, e2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;

  logic       o_lock, o_wrap, o_err;
  logic [7:0] o_ec;

  always #5 clk = ~clk;

  cnt_seq_checker u_def (
    .clk(clk), .rst(rst), .pi_cnt(cnt), .pi_vld(vld),
    .po_lock(l0), .po_wrap(w0), .po_err(e0), .po_err_cnt(ec0)
  );

  cnt_seq_checker #(.CNT_MAX(9)) u_c9 (
    .clk(clk), .rst(rst), .pi_cnt(cnt), .pi_vld(vld),
    .po_lock(l1), .po_wrap(w1), .po_err(e1), .po_err_cnt(ec1)
  );

  cnt_seq_checker #(.ERR_W(2)) u_e2 (
    .clk(clk), .rst(rst), .pi_cnt(cnt), .pi_vld(vld),
    .po_lock(l2), .po_wrap(w2), .po_err(e2), .po_err_cnt(ec2)
  );

  always_comb begin
    o_lock = l0; o_wrap = w0; o_err = e0; o_ec = ec0;
    case (sel)
      1: begin o_lock = l1; o_wrap = w1; o_err = e1; o_ec = ec1; end
      2: begin o_lock = l2; o_wrap = w2; o_err = e2; o_ec = {6'd0, ec2}; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic       lock;
    logic       wrap;
    logic       err;
    logic [7:0] ec;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_state, m_prev, m_run, m_ec, m_cmax, m_emax;
  // per-phase observations
  int n_samp, lock_at, wrap_seen, err_seen;
  bit lock_seen;
  int c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_run = 0; m_ec = 0;
    n_samp = 0; lock_at = 0; wrap_seen = 0; err_seen = 0; lock_seen = 0;
  endtask

  task automatic drive(input int val, input bit v);
    exp_t e;
    int   expd;
    bit   ok;
    e.wrap = 1'b0;
    e.err  = 1'b0;
    if (v) begin
      expd = (m_prev == m_cmax) ? 0 : m_prev + 1;
      ok   = (val <= m_cmax) && (val == expd);
      case (m_state)
        0: begin m_state = 1; m_run = 0; end
        1: begin
          if (ok) begin
            if (m_run + 1 == 4) begin m_state = 2; m_run = 0; end
            else m_run = m_run + 1;
          end else m_run = 0;
        end
        default: begin
          if (ok) e.wrap = (m_prev == m_cmax);
          else begin
            e.err = 1'b1;
            if (m_ec < m_emax) m_ec = m_ec + 1;
            m_run = 0; m_state = 1;
          end
        end
      endcase
      m_prev = val;
    end
    e.lock = (m_state == 2);
    e.ec   = 8'(m_ec);
    sb_q.push_back(e);
    cnt = 4'(val);
    vld = v;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("lock", 32'(o_lock), 32'(e.lock));
    chk("wrap", 32'(o_wrap), 32'(e.wrap));
    chk("err",  32'(o_err),  32'(e.err));
    chk("errcnt", 32'(o_ec), 32'(e.ec));
    if (v) n_samp++;
    if (o_wrap) wrap_seen++;
    if (o_err) err_seen++;
    if (o_lock && !lock_seen) begin lock_seen = 1; lock_at = n_samp; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(c, 1'b1);
      c = (c == m_cmax) ? 0 : c + 1;
    end
  endtask

  task automatic do_reset();
    vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_lock", 32'(o_lock), 32'd0);
    chk("rst_wrap", 32'(o_wrap), 32'd0);
    chk("rst_err",  32'(o_err),  32'd0);
    chk("rst_ec",   32'(o_ec),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    m_cmax = 15; m_emax = 255;
    model_reset();
    #2;

    // default instance: free-running counter
    sel = 0;
    do_reset();
    c = 0;
    run(40);
    chk("lock_at_5", 32'(lock_at), 32'd5);
    chk("wraps_16", 32'(wrap_seen), 32'd2);
    chk("no_err", 32'(err_seen), 32'd0);

    // inject 7 where 4 is expected, then continue 8, 9, ...
    while (c != 4) run(1);
    lock_seen = 0;
    drive(7, 1'b1);
    chk("inj_lock_drop", 32'(o_lock), 32'd0);
    c = 8;
    n_samp = 0;
    run(6);
    chk("inj_err_once", 32'(err_seen), 32'd1);
    chk("inj_ec", 32'(o_ec), 32'd1);
    chk("inj_relock_at_4", 32'(lock_at), 32'd4);

    // reset while locked
    do_reset();
    c = 3;
    run(8);
    chk("post_rst_lock_at", 32'(lock_at), 32'd5);

    // valid toggling, counter advancing only on valid cycles
    do_reset();
    c = 0;
    for (int i = 0; i < 14; i++) begin
      drive(c, 1'b1);
      c = (c == m_cmax) ? 0 : c + 1;
      drive($urandom_range(0, 15), 1'b0);
    end
    chk("tog_lock_at", 32'(lock_at), 32'd5);
    chk("tog_no_err", 32'(err_seen), 32'd0);

    // CNT_MAX=9 instance
    sel = 1; m_cmax = 9; m_emax = 255;
    do_reset();
    c = 0;
    run(35);
    chk("c9_wraps", 32'(wrap_seen), 32'd3);
    chk("c9_no_err", 32'(err_seen), 32'd0);
    chk("c9_lock_at", 32'(lock_at), 32'd5);

    // ERR_W=2 instance: five locked mismatches
    sel = 2; m_cmax = 15; m_emax = 3;
    do_reset();
    c = 0;
    run(6);
    for (int k = 0; k < 5; k++) begin
      drive((c + 5) & 15, 1'b1);
      c = (((c + 5) & 15) == 15) ? 0 : ((c + 5) & 15) + 1;
      run(6);
    end
    chk("e2_err_pulses", 32'(err_seen), 32'd5);
    chk("e2_sat", 32'(o_ec), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
